// File: rtl/dds_pkg.sv
// Shared DDS address map and loader state encoding.
// Imported by the config loader and by the DDS core so both agree on buffer selects.
package dds_pkg;

    localparam logic [8:0] THETAS    = 9'd0;
    localparam logic [8:0] DELTAS    = 9'd1;
    localparam logic [8:0] AMPLS     = 9'd2;
    localparam logic [8:0] IDLE_ADDR = 9'd511;

    // One config word carries theta, delta and amplitude, in that order from the LSBs.
    localparam int NUM_FIELDS = 3;

    typedef enum logic [2:0] {
        CLR,
        IDLE,
        WR_THETA,
        WR_DELTA,
        WR_AMPL,
        LOADED,
        RUN
    } ldr_state_t;

    // Buffer select to drive while sitting in a given state.
    function automatic logic [8:0] write_addr(input ldr_state_t s);
        case (s)
            WR_THETA: return THETAS;
            WR_DELTA: return DELTAS;
            WR_AMPL:  return AMPLS;
            default:  return IDLE_ADDR;
        endcase
    endfunction

endpackage

// File: rtl/dds_cfg_loader_if.sv
// Valid/ready channel carrying packed {ampl, delta, theta} config words into the loader.
interface dds_cfg_loader_if #(
    parameter int SIG_WIDTH = 16
) ();

    logic                     i_cfg_valid;
    logic                     o_cfg_ready;
    logic [3*SIG_WIDTH-1:0]   i_cfg_data;

    modport master (
        output i_cfg_valid,
        output i_cfg_data,
        input  o_cfg_ready
    );

    modport slave (
        input  i_cfg_valid,
        input  i_cfg_data,
        output o_cfg_ready
    );

endinterface

// File: rtl/dds_cfg_loader.sv
// Loads NUM_CH channel configs into the DDS shift buffers, then enables circulation.
// Define DDS_LDR_AUTOSTART_EN to start running as soon as all channels are loaded.
module dds_cfg_loader
    import dds_pkg::*;
#(
    parameter int SIG_WIDTH = 16,
    parameter int NUM_CH    = 8
) (
    input  logic                             clk,
    input  logic                             a_rst_n,
    dds_cfg_loader_if.slave                  cfg,
    input  logic                             i_start,
    input  logic                             i_stop,
    output logic                             o_dds_rst,
    output logic                             o_dds_start,
    output logic [8:0]                       o_dds_addrs,
    output logic signed [SIG_WIDTH-1:0]      o_dds_fifo_data,
    output logic [$clog2(NUM_CH+1)-1:0]      o_loaded_cnt,
    output logic                             o_busy
);

    localparam int CNT_W = $clog2(NUM_CH + 1);

    ldr_state_t                    state_reg, state_next;
    logic [3*SIG_WIDTH-1:0]        word_reg, word_next;
    logic [CNT_W-1:0]              cnt_reg, cnt_next;
    logic [8:0]                    addrs_next;
    logic signed [SIG_WIDTH-1:0]   data_next;
    logic signed [SIG_WIDTH-1:0]   field [NUM_FIELDS];

    // Field slices of the word being written; word_next already holds a freshly
    // accepted word so the theta write can go out in the cycle after the handshake.
    generate
        for (genvar gi = 0; gi < NUM_FIELDS; gi++) begin : g_field
            assign field[gi] = $signed(word_next[gi*SIG_WIDTH +: SIG_WIDTH]);
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        word_next  = word_reg;
        cnt_next   = cnt_reg;
        // Stop overrides every other request, including a handshake in the same cycle.
        if (i_stop && state_reg != CLR) begin
            state_next = CLR;
        end else begin
            case (state_reg)
                CLR:      state_next = IDLE;
                IDLE: begin
                    if (cfg.i_cfg_valid && cfg.o_cfg_ready) begin
                        word_next  = cfg.i_cfg_data;
                        state_next = WR_THETA;
                    end
                end
                WR_THETA: state_next = WR_DELTA;
                WR_DELTA: state_next = WR_AMPL;
                WR_AMPL: begin
                    cnt_next   = cnt_reg + CNT_W'(1);
                    state_next = (cnt_reg == CNT_W'(NUM_CH - 1)) ? LOADED : IDLE;
                end
                LOADED: begin
`ifdef DDS_LDR_AUTOSTART_EN
                    state_next = RUN;
`else
                    if (i_start) begin
                        state_next = RUN;
                    end
`endif
                end
                RUN:      state_next = RUN;
                default:  state_next = CLR;
            endcase
        end
        if (state_next == CLR) begin
            cnt_next = '0;
        end
    end

    // Outputs are decoded from the next state so that, once registered, they line up
    // with the state the loader is actually in.
    always_comb begin
        addrs_next = write_addr(state_next);
        data_next  = '0;
        case (state_next)
            WR_THETA: data_next = field[0];
            WR_DELTA: data_next = field[1];
            WR_AMPL:  data_next = field[2];
            default:  data_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            state_reg       <= CLR;
            word_reg        <= '0;
            cnt_reg         <= '0;
            o_dds_rst       <= 1'b1;
            o_dds_start     <= 1'b0;
            o_dds_addrs     <= IDLE_ADDR;
            o_dds_fifo_data <= '0;
            cfg.o_cfg_ready <= 1'b0;
            o_busy          <= 1'b1;
        end else begin
            state_reg       <= state_next;
            word_reg        <= word_next;
            cnt_reg         <= cnt_next;
            o_dds_rst       <= (state_next == CLR);
            o_dds_start     <= (state_next == RUN);
            o_dds_addrs     <= addrs_next;
            o_dds_fifo_data <= data_next;
            cfg.o_cfg_ready <= (state_next == IDLE);
            o_busy          <= (state_next != IDLE);
        end
    end

    assign o_loaded_cnt = cnt_reg;

endmodule

// File: tb/tb_dds_cfg_loader.sv
// Randomized self-checking bench for dds_cfg_loader against a word-level write model.
module tb_dds_cfg_loader;

    localparam int SW = 16;
    localparam int NC = 8;

    logic                   clk = 1'b0;
    logic                   a_rst_n = 1'b1;
    logic                   i_start = 1'b0;
    logic                   i_stop = 1'b0;
    logic                   o_dds_rst;
    logic                   o_dds_start;
    logic [8:0]             o_dds_addrs;
    logic signed [SW-1:0]   o_dds_fifo_data;
    logic [3:0]             o_loaded_cnt;
    logic                   o_busy;

    dds_cfg_loader_if #(.SIG_WIDTH(SW)) cfg ();

    dds_cfg_loader #(.SIG_WIDTH(SW), .NUM_CH(NC)) dut (
        .clk             (clk),
        .a_rst_n         (a_rst_n),
        .cfg             (cfg),
        .i_start         (i_start),
        .i_stop          (i_stop),
        .o_dds_rst       (o_dds_rst),
        .o_dds_start     (o_dds_start),
        .o_dds_addrs     (o_dds_addrs),
        .o_dds_fifo_data (o_dds_fifo_data),
        .o_loaded_cnt    (o_loaded_cnt),
        .o_busy          (o_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [8:0]    addr;
        logic [SW-1:0] data;
    } wr_t;

    wr_t obs_q[$];
    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  viol  = 0;

    // Observe every DDS buffer write and check the idle-address rules on each cycle.
    always @(negedge clk) begin
        if (a_rst_n) begin
            if (o_dds_addrs != 9'd511) begin
                obs_q.push_back({o_dds_addrs, o_dds_fifo_data});
                if (o_dds_addrs > 9'd2 || o_dds_start || cfg.o_cfg_ready || o_dds_rst || !o_busy)
                    viol++;
            end else if (o_dds_fifo_data != '0) begin
                viol++;
            end
        end
    end

    function automatic logic [3*SW-1:0] rand_word();
        return {16'($urandom), 16'($urandom), 16'($urandom)};
    endfunction

    // Reference: an accepted word yields theta, delta, ampl writes to buffers 0, 1, 2.
    task automatic push_exp(input logic [3*SW-1:0] w, input int nfields);
        for (int f = 0; f < nfields; f++)
            exp_q.push_back({9'(f), w[f*SW +: SW]});
    endtask

    // Streams n random words with valid held high; returns how many were accepted.
    task automatic load_words(input int n, output int got);
        got = 0;
        cfg.i_cfg_valid = 1'b0;
        for (int k = 0; k < 20 * n && got < n; k++) begin
            if (!cfg.i_cfg_valid) begin
                cfg.i_cfg_data  = rand_word();
                cfg.i_cfg_valid = 1'b1;
            end
            if (cfg.o_cfg_ready) begin
                push_exp(cfg.i_cfg_data, 3);
                got++;
                $display("word %0d accepted data=%h", got, cfg.i_cfg_data);
                @(negedge clk);
                cfg.i_cfg_valid = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        cfg.i_cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        a_rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (o_dds_rst !== 1'b1 || o_dds_start !== 1'b0 || o_dds_addrs !== 9'd511 ||
            o_dds_fifo_data !== 16'sd0 || cfg.o_cfg_ready !== 1'b0 || o_loaded_cnt !== 4'd0 || o_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_values: got rst=%b start=%b addr=%0d data=%h ready=%b cnt=%0d busy=%b, want 1 0 511 0000 0 0 1",
                     o_dds_rst, o_dds_start, o_dds_addrs, o_dds_fifo_data, cfg.o_cfg_ready, o_loaded_cnt, o_busy);
        end
        @(posedge clk);
        #1 a_rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (o_dds_rst !== 1'b1 || o_busy !== 1'b1 || cfg.o_cfg_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL release_clr: got rst=%b busy=%b ready=%b, want 1 1 0", o_dds_rst, o_busy, cfg.o_cfg_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (o_dds_rst !== 1'b0 || cfg.o_cfg_ready !== 1'b1 || o_busy !== 1'b0 || o_dds_addrs !== 9'd511) begin
            n_bad++;
            $display("FAIL release_idle: got rst=%b ready=%b busy=%b addr=%0d, want 0 1 0 511",
                     o_dds_rst, cfg.o_cfg_ready, o_busy, o_dds_addrs);
        end
        $display("reset sequence done");
    endtask

    task automatic test_single_word();
        logic [3*SW-1:0] w;
        int              model_cnt;
        model_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            w = (k == 0) ? 48'h7FFF_0100_0040 : rand_word();
            n_cmp++;
            if (cfg.o_cfg_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL ready_before_word%0d: got %b want 1", k, cfg.o_cfg_ready);
            end
            cfg.i_cfg_valid = 1'b1;
            cfg.i_cfg_data  = w;
            @(negedge clk);
            cfg.i_cfg_valid = 1'b0;
            for (int f = 0; f < 3; f++) begin
                n_cmp++;
                if (o_dds_addrs !== 9'(f) || o_dds_fifo_data !== w[f*SW +: SW] || cfg.o_cfg_ready !== 1'b0) begin
                    n_bad++;
                    $display("FAIL write_w%0d_f%0d: got addr=%0d data=%h ready=%b, want addr=%0d data=%h ready=0",
                             k, f, o_dds_addrs, o_dds_fifo_data, cfg.o_cfg_ready, f, w[f*SW +: SW]);
                end
                @(negedge clk);
            end
            model_cnt++;
            n_cmp++;
            if (cfg.o_cfg_ready !== 1'b1 || o_loaded_cnt !== 4'(model_cnt) || o_dds_addrs !== 9'd511) begin
                n_bad++;
                $display("FAIL after_word%0d: got ready=%b cnt=%0d addr=%0d, want 1 %0d 511",
                         k, cfg.o_cfg_ready, o_loaded_cnt, o_dds_addrs, model_cnt);
            end
            $display("single word %0d data=%h loaded_cnt=%0d", k, w, o_loaded_cnt);
        end
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        n_cmp++;
        if (o_dds_start !== 1'b0 || cfg.o_cfg_ready !== 1'b1 || o_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL start_in_idle: got start=%b ready=%b busy=%b, want 0 1 0", o_dds_start, cfg.o_cfg_ready, o_busy);
        end
    endtask

    task automatic test_back_to_back();
        int got;
        i_stop = 1'b1;
        @(negedge clk);
        i_stop = 1'b0;
        n_cmp++;
        if (o_dds_rst !== 1'b1 || o_loaded_cnt !== 4'd0) begin
            n_bad++;
            $display("FAIL stop_clear: got rst=%b cnt=%0d, want 1 0", o_dds_rst, o_loaded_cnt);
        end
        @(negedge clk);
        obs_q.delete();
        exp_q.delete();
        load_words(NC, got);
        n_cmp++;
        if (got !== NC) begin
            n_bad++;
            $display("FAIL b2b_accept_count: got %0d want %0d", got, NC);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (o_loaded_cnt !== 4'd8 || cfg.o_cfg_ready !== 1'b0 || o_dds_start !== 1'b0 || o_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL loaded_state: got cnt=%0d ready=%b start=%b busy=%b, want 8 0 0 1",
                     o_loaded_cnt, cfg.o_cfg_ready, o_dds_start, o_busy);
        end
`ifdef DDS_LDR_AUTOSTART_EN
        @(negedge clk);
`else
        repeat (2) @(negedge clk);
        n_cmp++;
        if (o_dds_start !== 1'b0) begin
            n_bad++;
            $display("FAIL waits_for_start: got start=%b want 0", o_dds_start);
        end
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
`endif
        n_cmp++;
        if (o_dds_start !== 1'b1 || cfg.o_cfg_ready !== 1'b0 || o_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL run_entry: got start=%b ready=%b busy=%b, want 1 0 1", o_dds_start, cfg.o_cfg_ready, o_busy);
        end
        cfg.i_cfg_data  = rand_word();
        cfg.i_cfg_valid = 1'b1;
        repeat (4) @(negedge clk);
        cfg.i_cfg_valid = 1'b0;
        n_cmp++;
        if (o_dds_start !== 1'b1 || o_loaded_cnt !== 4'd8) begin
            n_bad++;
            $display("FAIL run_hold: got start=%b cnt=%0d, want 1 8", o_dds_start, o_loaded_cnt);
        end
        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin
            n_bad++;
            $display("FAIL b2b_write_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_bad++;
                    $display("FAIL b2b_write%0d: got addr=%0d data=%h want addr=%0d data=%h",
                             i, obs_q[i].addr, obs_q[i].data, exp_q[i].addr, exp_q[i].data);
                end
            end
        end
        i_stop = 1'b1;
        @(negedge clk);
        i_stop = 1'b0;
        n_cmp++;
        if (o_dds_rst !== 1'b1 || o_dds_start !== 1'b0 || o_loaded_cnt !== 4'd0) begin
            n_bad++;
            $display("FAIL run_stop: got rst=%b start=%b cnt=%0d, want 1 0 0", o_dds_rst, o_dds_start, o_loaded_cnt);
        end
        @(negedge clk);
        n_cmp++;
        if (o_dds_rst !== 1'b0 || cfg.o_cfg_ready !== 1'b1 || o_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL run_stop_idle: got rst=%b ready=%b busy=%b, want 0 1 0", o_dds_rst, cfg.o_cfg_ready, o_busy);
        end
        $display("back-to-back load of %0d words, %0d writes seen", got, obs_q.size());
    endtask

    task automatic test_stop_mid_word();
        int              got;
        logic [3*SW-1:0] w;
        obs_q.delete();
        exp_q.delete();
        load_words(2, got);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (got !== 2 || cfg.o_cfg_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_preload: got accepted=%0d ready=%b, want 2 1", got, cfg.o_cfg_ready);
        end
        w = rand_word();
        cfg.i_cfg_data  = w;
        cfg.i_cfg_valid = 1'b1;
        @(negedge clk);
        cfg.i_cfg_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (o_dds_addrs !== 9'd1) begin
            n_bad++;
            $display("FAIL mid_in_delta: got addr=%0d want 1", o_dds_addrs);
        end
        i_stop = 1'b1;
        @(negedge clk);
        i_stop = 1'b0;
        push_exp(w, 2);
        n_cmp++;
        if (o_dds_rst !== 1'b1 || o_dds_addrs !== 9'd511 || o_loaded_cnt !== 4'd0) begin
            n_bad++;
            $display("FAIL mid_stop_clr: got rst=%b addr=%0d cnt=%0d, want 1 511 0", o_dds_rst, o_dds_addrs, o_loaded_cnt);
        end
        @(negedge clk);
        n_cmp++;
        if (o_dds_rst !== 1'b0 || cfg.o_cfg_ready !== 1'b1 || o_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_stop_idle: got rst=%b ready=%b busy=%b, want 0 1 0", o_dds_rst, cfg.o_cfg_ready, o_busy);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin
            n_bad++;
            $display("FAIL mid_write_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_bad++;
                    $display("FAIL mid_write%0d: got addr=%0d data=%h want addr=%0d data=%h",
                             i, obs_q[i].addr, obs_q[i].data, exp_q[i].addr, exp_q[i].data);
                end
            end
        end
        $display("stop during delta write of word 3, %0d writes seen", obs_q.size());
    endtask

    task automatic test_stop_vs_handshake();
        obs_q.delete();
        cfg.i_cfg_data  = rand_word();
        cfg.i_cfg_valid = 1'b1;
        i_stop          = 1'b1;
        @(negedge clk);
        cfg.i_cfg_valid = 1'b0;
        i_stop          = 1'b0;
        n_cmp++;
        if (o_dds_rst !== 1'b1 || cfg.o_cfg_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL stop_beats_word: got rst=%b ready=%b, want 1 0", o_dds_rst, cfg.o_cfg_ready);
        end
        repeat (4) @(negedge clk);
        n_cmp++;
        if (obs_q.size() !== 0 || o_loaded_cnt !== 4'd0 || cfg.o_cfg_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL dropped_word: got writes=%0d cnt=%0d ready=%b, want 0 0 1", obs_q.size(), o_loaded_cnt, cfg.o_cfg_ready);
        end
        $display("stop with simultaneous handshake, writes=%0d", obs_q.size());
    endtask

    task automatic test_start_stop_together();
        int got;
        obs_q.delete();
        exp_q.delete();
        load_words(NC, got);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (got !== NC || o_loaded_cnt !== 4'd8 || o_dds_start !== 1'b0) begin
            n_bad++;
            $display("FAIL ss_loaded: got accepted=%0d cnt=%0d start=%b, want 8 8 0", got, o_loaded_cnt, o_dds_start);
        end
        i_start = 1'b1;
        i_stop  = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        i_stop  = 1'b0;
        n_cmp++;
        if (o_dds_rst !== 1'b1 || o_dds_start !== 1'b0 || o_loaded_cnt !== 4'd0) begin
            n_bad++;
            $display("FAIL ss_clr: got rst=%b start=%b cnt=%0d, want 1 0 0", o_dds_rst, o_dds_start, o_loaded_cnt);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (o_dds_start !== 1'b0 || cfg.o_cfg_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL ss_after%0d: got start=%b ready=%b, want 0 1", c, o_dds_start, cfg.o_cfg_ready);
            end
        end
        $display("start+stop together in LOADED, start=%b", o_dds_start);
    endtask

    initial begin
        cfg.i_cfg_valid = 1'b0;
        cfg.i_cfg_data  = '0;
        #2;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_stop_mid_word();
        test_stop_vs_handshake();
        test_start_stop_together();
        n_cmp++;
        if (viol !== 0) begin
            n_bad++;
            $display("FAIL idle_addr_rule: got %0d violating cycles want 0", viol);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dds_cfg_loader.md
DDS_CFG_LOADER -- requirements
Module: dds_cfg_loader

Interface
REQ-001 SHALL have parameter SIG_WIDTH, default 16: width of each theta/delta/amplitude word.
REQ-002 SHALL have parameter NUM_CH, default 8: channel count per load; equals the DDS shift-register depth.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on the rising edge.
REQ-004 SHALL have port a_rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port i_cfg_valid, input, 1: a channel config word is offered.
REQ-006 SHALL have port o_cfg_ready, output, 1: the loader accepts the offered word.
REQ-007 SHALL have port i_cfg_data, input, 3*SIG_WIDTH: packed {ampl, delta, theta}, with theta in the LSBs.
REQ-008 SHALL have port i_start, input, 1: single-cycle run request.
REQ-009 SHALL have port i_stop, input, 1: single-cycle abort/stop request.
REQ-010 SHALL have port o_dds_rst, output, 1: synchronous clear to the DDS.
REQ-011 SHALL have port o_dds_start, output, 1: DDS circulate enable.
REQ-012 SHALL have port o_dds_addrs, output, 9: DDS buffer select.
REQ-013 SHALL have port o_dds_fifo_data, output, SIG_WIDTH, signed: DDS buffer write data.
REQ-014 SHALL have port o_loaded_cnt, output, clog2(NUM_CH+1): number of channels loaded.
REQ-015 SHALL have port o_busy, output, 1: high in every state except IDLE.

Function
REQ-016 SHALL implement the states CLR, IDLE, WR_THETA, WR_DELTA, WR_AMPL, LOADED and RUN, with every output registered.
REQ-017 SHALL drive o_dds_addrs to IDLE_ADDR (511) whenever no write is being issued, so that the DDS decoder never writes unintentionally.
REQ-018 CLR SHALL drive o_dds_rst=1 for exactly one cycle, clear o_loaded_cnt, then go to IDLE.
REQ-019 IDLE SHALL drive o_cfg_ready=1; on i_cfg_valid&&o_cfg_ready it SHALL capture i_cfg_data and go to WR_THETA.
REQ-020 WR_THETA, WR_DELTA and WR_AMPL SHALL each drive one write in consecutive cycles, using address THETAS(0), DELTAS(1) and AMPLS(2) with the matching captured field; o_cfg_ready=0 in all three.
REQ-021 After WR_AMPL, o_loaded_cnt SHALL increment; the next state SHALL be LOADED if the count equals NUM_CH, else IDLE.
REQ-022 Handshake latency SHALL be: word accepted at edge t; writes visible in cycles t+1, t+2 and t+3; o_cfg_ready high again at t+4 when the count is below NUM_CH.
REQ-023 LOADED SHALL hold o_cfg_ready=0 and leave the state when i_start is seen (see REQ-031).
REQ-024 RUN SHALL hold o_dds_start=1 and o_cfg_ready=0 until i_stop.
REQ-025 i_stop in any state other than CLR SHALL go to CLR next cycle; any in-flight word SHALL be dropped.
REQ-026 i_stop SHALL win over a simultaneous i_start or cfg handshake; a word offered in that cycle SHALL NOT be accepted.
REQ-027 i_start outside LOADED SHALL be ignored.
REQ-028 o_dds_fifo_data SHALL be 0 whenever no write is being issued.

Reset
REQ-029 a_rst_n low SHALL force state CLR and outputs o_dds_rst=1, o_dds_start=0, o_dds_addrs=IDLE_ADDR, o_dds_fifo_data=0, o_cfg_ready=0, o_loaded_cnt=0 and o_busy=1.
REQ-030 After reset release, the first cycle SHALL remain CLR, pulsing o_dds_rst to flush the DDS buffers, then the block SHALL enter IDLE.

Configuration
REQ-031 With DDS_LDR_AUTOSTART_EN defined, LOADED SHALL go to RUN on the following cycle without i_start; without the macro, LOADED SHALL wait for i_start, then go to RUN.

Structure
REQ-032 Package dds_pkg SHALL hold THETAS, DELTAS, AMPLS, IDLE_ADDR and the loader state enum typedef; dds SHALL import the same address constants.
REQ-033 SHALL be a single module with no sub-module; the phase-write sequencing is too small to split.

Verification (SIG_WIDTH=16, NUM_CH=8)
REQ-034 Reset release -> o_dds_rst=1 for one cycle, then o_cfg_ready=1, o_busy=0, o_dds_addrs=511.
REQ-035 Offer {0x7FFF,0x0100,0x0040} at edge t -> writes addr0/0x0040, addr1/0x0100, addr2/0x7FFF in cycles t+1..t+3, o_loaded_cnt=1, o_cfg_ready=1 at t+4.
REQ-036 Eight back-to-back words, then an i_start pulse -> o_loaded_cnt=8, o_cfg_ready stays 0, o_dds_start=1 from the cycle after i_start; with the macro, o_dds_start=1 without i_start.
REQ-037 Assert i_stop during WR_DELTA of word 3 -> no AMPLS write, o_dds_rst pulses once, o_loaded_cnt=0, IDLE follows.
REQ-038 i_start and i_stop together in LOADED -> CLR, o_dds_start stays 0.
REQ-039 Over the whole test, no cycle outside WR_* shows o_dds_addrs in {0,1,2} while o_dds_start=0 (checked by assertion).
